// File: rtl/lcd_block_pkg.sv
// Shared types and constants for the LCD block sprite controller.
// States, the CLEAR/DRAW phase type, LCD command bytes and the payload pattern helper.
package lcd_block_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SET_Y,
        SET_X,
        WR_BYTE,
        NEXT_ROW,
        DONE
    } state_e;

    typedef enum logic {
        PH_CLEAR,
        PH_DRAW
    } phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h30;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISPLAY  = 8'h0C;
    localparam logic [7:0] CMD_EXT_GFX  = 8'h36;
    localparam logic [7:0] CMD_ADDR     = 8'h80;

    function automatic logic [7:0] initCommand(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_ENTRY;
            2'd2:    cmd = CMD_DISPLAY;
            default: cmd = CMD_EXT_GFX;
        endcase
        return cmd;
    endfunction

    // An odd x straddles two 16-bit words, so the 16-pixel block sits in the middle of four bytes.
    function automatic logic [7:0] payloadByte(input phase_e phase, input logic oddX, input logic [1:0] idx);
        logic [7:0] b;
        if (phase == PH_CLEAR) begin
            b = 8'h00;
        end else if (!oddX) begin
            b = 8'hFF;
        end else begin
            b = (idx == 2'd1 || idx == 2'd2) ? 8'hFF : 8'h00;
        end
        return b;
    endfunction

endpackage

// File: rtl/lcd_key_debounce.sv
// Debouncer for one active-low asynchronous key: synchronised level plus one-clk press strobe.
// With LCD_BLOCK_AUTOREPEAT_EN defined, a long hold also emits repeat strobes.
module lcd_key_debounce #(
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic keyN_i,
    output logic pressed_o,
    output logic strobe_o
);

    localparam int CW = DEBOUNCE_BITS + 1;
    localparam logic [CW-1:0] PRESS_MAX = CW'(1) << DEBOUNCE_BITS;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;
    logic          keyLow;
    logic          repeatHit;

    assign keyLow    = ~sync_q[1];
    assign pressed_o = (cnt_q == PRESS_MAX);
    assign strobe_o  = strobe_q;

`ifdef LCD_BLOCK_AUTOREPEAT_EN
    localparam int RW = DEBOUNCE_BITS + 4;
    localparam logic [RW-1:0] REP_FIRST  = RW'(1) << (DEBOUNCE_BITS + 3);
    localparam logic [RW-1:0] REP_PERIOD = RW'(1) << (DEBOUNCE_BITS + 2);

    logic [RW-1:0] rep_q, rep_d;

    // Reloading below the first threshold makes every later repeat one period apart.
    always_comb begin
        rep_d     = rep_q;
        repeatHit = 1'b0;
        if (!keyLow || !pressed_o) begin
            rep_d = '0;
        end else if (rep_q == REP_FIRST - 1'b1) begin
            rep_d     = REP_FIRST - REP_PERIOD;
            repeatHit = 1'b1;
        end else begin
            rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    assign repeatHit = 1'b0;
`endif

    // The counter saturates at the press threshold so a long hold never re-triggers by wrapping.
    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = repeatHit;
        if (!keyLow) begin
            cnt_d = '0;
        end else if (cnt_q != PRESS_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PRESS_MAX - 1'b1) strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], keyN_i};
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: rtl/lcd_block_sprite_ctrl.sv
// Moves a 16-pixel-wide block around a 128x64 graphic LCD from four keys, redrawing over a slow byte bus.
// Optional LCD_BLOCK_AUTOREPEAT_EN adds key auto-repeat inside the debouncers.
module lcd_block_sprite_ctrl
    import lcd_block_pkg::*;
#(
    parameter int CLK_DIV       = 2499,
    parameter int DEBOUNCE_BITS = 20,
    parameter int BLK_ROWS      = 16,
    parameter int STEP_Y        = 4,
    parameter int INIT_X        = 7,
    parameter int INIT_Y        = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic       rs_o,
    output logic       rw_o,
    output logic       en_o,
    output logic [7:0] data_o,
    output logic       busy_o,
    output logic [3:0] pos_x_o,
    output logic [5:0] pos_y_o
);

    localparam int STEP_LEN = 2 * (CLK_DIV + 1);
    localparam int DW       = $clog2(STEP_LEN);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    initIdx_q, initIdx_d;
    logic [4:0]    rowIdx_q, rowIdx_d;
    logic [1:0]    byteIdx_q, byteIdx_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          byteValid_q, byteValid_d;
    logic [3:0]    posX_q, posX_d, drawX_q, drawX_d;
    logic [5:0]    posY_q, posY_d, drawY_q, drawY_d;

    logic [3:0] keysN, lvl, stb;
    logic       tick;
    logic [5:0] row;

    assign keysN = {up_i, down_i, left_i, right_i};

    for (genvar k = 0; k < 4; k++) begin : g_key
        lcd_key_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_debounce (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .keyN_i   (keysN[k]),
            .pressed_o(lvl[k]),
            .strobe_o (stb[k])
        );
    end

    assign tick    = (div_q == DW'(STEP_LEN - 1));
    assign div_d   = tick ? '0 : div_q + 1'b1;
    assign row     = drawY_q + {1'b0, rowIdx_q};
    assign rs_o    = rs_q;
    assign rw_o    = 1'b0;
    assign en_o    = byteValid_q && (div_q > DW'(CLK_DIV));
    assign data_o  = data_q;
    assign busy_o  = (state_q != IDLE);
    assign pos_x_o = posX_q;
    assign pos_y_o = posY_q;

    // A press is cancelled by its opposite key being held, which also covers both strobing together.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        initIdx_d   = initIdx_q;
        rowIdx_d    = rowIdx_q;
        byteIdx_d   = byteIdx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        byteValid_d = byteValid_q;
        posX_d      = posX_q;
        posY_d      = posY_q;
        drawX_d     = drawX_q;
        drawY_d     = drawY_q;

        if (state_q == IDLE && stb != 4'b0000) begin
            if (stb[3] && !lvl[2]) posY_d = posY_q - 6'(STEP_Y);
            if (stb[2] && !lvl[3]) posY_d = posY_q + 6'(STEP_Y);
            if (stb[1] && !lvl[0]) posX_d = (posX_q == 4'd0) ? 4'd14 : posX_q - 4'd1;
            if (stb[0] && !lvl[1]) posX_d = (posX_q == 4'd14) ? 4'd0 : posX_q + 4'd1;
            drawX_d  = posX_q;
            drawY_d  = posY_q;
            phase_d  = PH_CLEAR;
            rowIdx_d = '0;
            state_d  = SET_Y;
        end

        // Everything below advances once per LCD step; steps that carry no byte leave en low.
        if (tick) begin
            byteValid_d = 1'b0;
            rs_d        = 1'b0;
            data_d      = 8'h00;
            case (state_q)
                INIT: begin
                    byteValid_d = 1'b1;
                    data_d      = initCommand(initIdx_q);
                    if (initIdx_q == 2'd3) begin
                        phase_d  = PH_DRAW;
                        rowIdx_d = '0;
                        state_d  = SET_Y;
                    end else begin
                        initIdx_d = initIdx_q + 2'd1;
                    end
                end
                SET_Y: begin
                    byteValid_d = 1'b1;
                    data_d      = CMD_ADDR | {3'b000, row[4:0]};
                    state_d     = SET_X;
                end
                SET_X: begin
                    byteValid_d = 1'b1;
                    data_d      = CMD_ADDR | {4'b0000, row[5], drawX_q[3:1]};
                    byteIdx_d   = '0;
                    state_d     = WR_BYTE;
                end
                WR_BYTE: begin
                    byteValid_d = 1'b1;
                    rs_d        = 1'b1;
                    data_d      = payloadByte(phase_q, drawX_q[0], byteIdx_q);
                    if (byteIdx_q == (drawX_q[0] ? 2'd3 : 2'd1)) state_d = NEXT_ROW;
                    else                                          byteIdx_d = byteIdx_q + 2'd1;
                end
                NEXT_ROW: begin
                    if (rowIdx_q == 5'(BLK_ROWS - 1)) begin
                        state_d = DONE;
                    end else begin
                        rowIdx_d = rowIdx_q + 5'd1;
                        state_d  = SET_Y;
                    end
                end
                DONE: begin
                    if (phase_q == PH_CLEAR) begin
                        phase_d  = PH_DRAW;
                        drawX_d  = posX_q;
                        drawY_d  = posY_q;
                        rowIdx_d = '0;
                        state_d  = SET_Y;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            phase_q     <= PH_DRAW;
            div_q       <= '0;
            initIdx_q   <= '0;
            rowIdx_q    <= '0;
            byteIdx_q   <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            byteValid_q <= 1'b0;
            posX_q      <= 4'(INIT_X);
            posY_q      <= 6'(INIT_Y);
            drawX_q     <= 4'(INIT_X);
            drawY_q     <= 6'(INIT_Y);
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            initIdx_q   <= initIdx_d;
            rowIdx_q    <= rowIdx_d;
            byteIdx_q   <= byteIdx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            byteValid_q <= byteValid_d;
            posX_q      <= posX_d;
            posY_q      <= posY_d;
            drawX_q     <= drawX_d;
            drawY_q     <= drawY_d;
        end
    end

endmodule

// File: tb/tb_lcd_block_sprite_ctrl.sv
// Self-checking bench: a byte-stream model of the LCD traffic plus position model, driven by directed and random key presses.
module tb_lcd_block_sprite_ctrl;

    localparam int CLK_DIV       = 1;
    localparam int DEBOUNCE_BITS = 3;
    localparam int BLK_ROWS      = 2;
    localparam int STEP_Y        = 4;
    localparam int INIT_X        = 7;
    localparam int INIT_Y        = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
    logic       rs, rw, en, busy;
    logic [7:0] data;
    logic [3:0] posX;
    logic [5:0] posY;

    lcd_block_sprite_ctrl #(
        .CLK_DIV(CLK_DIV), .DEBOUNCE_BITS(DEBOUNCE_BITS), .BLK_ROWS(BLK_ROWS),
        .STEP_Y(STEP_Y), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) dut (
        .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(down), .left_i(left), .right_i(right),
        .rs_o(rs), .rw_o(rw), .en_o(en), .data_o(data), .busy_o(busy),
        .pos_x_o(posX), .pos_y_o(posY)
    );

    always #5 clk = ~clk;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         byteCount = 0;
    int         modelX = INIT_X;
    int         modelY = INIT_Y;
    logic [8:0] expQ[$];
    logic [7:0] recvLog[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected traffic for one block: per row a Y address, an X address (half select in bit 3), then payload.
    task automatic modelBlock(input bit draw, input int x, input int y);
        for (int r = 0; r < BLK_ROWS; r++) begin
            int rowN = (y + r) % 64;
            expQ.push_back({1'b0, 8'h80 | 8'(rowN % 32)});
            expQ.push_back({1'b0, 8'h80 | 8'((rowN / 32) * 8 + x / 2)});
            if (x % 2 == 0) begin
                repeat (2) expQ.push_back({1'b1, draw ? 8'hFF : 8'h00});
            end else begin
                expQ.push_back(9'h100);
                repeat (2) expQ.push_back({1'b1, draw ? 8'hFF : 8'h00});
                expQ.push_back(9'h100);
            end
        end
    endtask

    task automatic pushInit();
        expQ.push_back(9'h030);
        expQ.push_back(9'h006);
        expQ.push_back(9'h00C);
        expQ.push_back(9'h036);
        modelBlock(1'b1, modelX, modelY);
    endtask

    // mask bits: [3]=up [2]=down [1]=left [0]=right
    task automatic planMove(input logic [3:0] mask, input int holdClk, output bit ev);
        int nx = modelX;
        int ny = modelY;
        ev = (mask != 4'b0000) && (holdClk >= (1 << DEBOUNCE_BITS));
        if (!ev) return;
        if (mask[3] && !mask[2]) ny = (ny + 64 - STEP_Y) % 64;
        if (mask[2] && !mask[3]) ny = (ny + STEP_Y) % 64;
        if (mask[1] && !mask[0]) nx = (nx == 0) ? 14 : nx - 1;
        if (mask[0] && !mask[1]) nx = (nx == 14) ? 0 : nx + 1;
        modelBlock(1'b0, modelX, modelY);
        modelBlock(1'b1, nx, ny);
        modelX = nx;
        modelY = ny;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s: busy=%b after %0d clk, want 0", name, busy, budget);
        end
    endtask

    task automatic driveMove(input logic [3:0] mask, input int holdClk, input bit ev);
        recvLog.delete();
        {up, down, left, right} = ~mask;
        tick(holdClk);
        {up, down, left, right} = 4'hF;
        if (ev) begin
            tick(5);
            waitIdle("move_idle", 600);
        end else begin
            tick(30);
            checkOutput("no_event_busy", busy, 0);
        end
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("pos_x", posX, modelX);
        checkOutput("pos_y", posY, modelY);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int holdClk);
        bit ev;
        planMove(mask, holdClk, ev);
        driveMove(mask, holdClk, ev);
    endtask

    task automatic checkInitLog();
        checkOutput("init_len", recvLog.size(), 4 + BLK_ROWS * 6);
        if (recvLog.size() >= 11) begin
            checkOutput("init_cmd0", recvLog[0], 8'h30);
            checkOutput("init_cmd1", recvLog[1], 8'h06);
            checkOutput("init_cmd2", recvLog[2], 8'h0C);
            checkOutput("init_cmd3", recvLog[3], 8'h36);
            checkOutput("init_y24", recvLog[4], 8'h98);
            checkOutput("init_x7", recvLog[5], 8'h83);
            checkOutput("init_pay0", recvLog[6], 8'h00);
            checkOutput("init_pay1", recvLog[7], 8'hFF);
            checkOutput("init_y25", recvLog[10], 8'h99);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rs", rs, 0);
        checkOutput("rst_en", en, 0);
        checkOutput("rst_data", data, 8'h00);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_pos_x", posX, INIT_X);
        checkOutput("rst_pos_y", posY, INIT_Y);
    endtask

    task automatic resetMidDraw();
        bit ev;
        int clearBytes = BLK_ROWS * (2 + ((modelX % 2 == 1) ? 4 : 2));
        int start;
        int n = 0;
        planMove(4'b0010, 10, ev);
        start = byteCount;
        left = 1'b0;
        tick(10);
        left = 1'b1;
        while (byteCount - start < clearBytes + 3 && n < 600) begin
            tick(1);
            n++;
        end
        testsRun++;
        if (byteCount - start < clearBytes + 3) begin
            testsFailed++;
            $display("[TB] FAIL draw_payload_reached: got %0d bytes, want %0d", byteCount - start, clearBytes + 3);
        end
        rst = 1'b1;
        tick(1);
        checkResetOutputs();
        expQ.delete();
        modelX = INIT_X;
        modelY = INIT_Y;
        tick(3);
        recvLog.delete();
        rst = 1'b0;
        pushInit();
        waitIdle("reinit_idle", 600);
        checkOutput("reinit_drained", expQ.size(), 0);
        checkInitLog();
    endtask

`ifdef LCD_BLOCK_AUTOREPEAT_EN
    task automatic repeatHoldTest(input int holdClk);
        int   rises = 0;
        logic prevBusy = 1'b0;
        up = 1'b0;
        down = 1'b0;
        for (int i = 0; i < holdClk; i++) begin
            tick(1);
            if (busy && !prevBusy) begin
                rises++;
                modelBlock(1'b0, modelX, modelY);
                modelBlock(1'b1, modelX, modelY);
            end
            prevBusy = busy;
        end
        up = 1'b1;
        down = 1'b1;
        waitIdle("repeat_idle", 600);
        testsRun++;
        if (rises < 2) begin
            testsFailed++;
            $display("[TB] FAIL autorepeat: got %0d events, want at least 2", rises);
        end
        checkOutput("repeat_drained", expQ.size(), 0);
    endtask
`endif

    // Byte capture: a byte is whatever rs/data hold while en is high, taken when en falls.
    logic       enPrev = 1'b0;
    logic       capRs = 1'b0;
    logic [7:0] capData = 8'h00;
    int         enWidth = 0;
    logic       stable = 1'b1;
    logic [8:0] expByte;

    always @(negedge clk) begin
        if (rst) begin
            enPrev = 1'b0;
        end else begin
            if (en && !enPrev) begin
                capRs = rs;
                capData = data;
                enWidth = 1;
                stable = 1'b1;
            end else if (en && enPrev) begin
                enWidth++;
                if ({rs, data} !== {capRs, capData}) stable = 1'b0;
            end else if (!en && enPrev) begin
                byteCount++;
                recvLog.push_back(capData);
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_byte: got rs=%b data=0x%02h, want no byte", capRs, capData);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("lcd_byte", {capRs, capData}, expByte);
                end
                checkOutput("en_width", enWidth, CLK_DIV + 1);
                checkOutput("bus_stable", stable, 1);
                checkOutput("rw_low", rw, 0);
                checkOutput("busy_during_byte", busy, 1);
            end
            enPrev = en;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ev;
        tick(4);
        checkResetOutputs();
        rst = 1'b0;
        pushInit();
        waitIdle("init_idle", 600);
        checkOutput("init_drained", expQ.size(), 0);
        checkInitLog();

        repeat (6) applyStimulus(4'b1000, 10);
        checkOutput("y_at_zero", posY, 0);

        // Row 60 is in the lower half: Y keeps row[4:0] and the half select moves into the X command.
        planMove(4'b1000, 8, ev);
        checkOutput("model_len_odd", expQ.size(), 24);
        checkOutput("model_clear_y0", expQ[0], 9'h080);
        checkOutput("model_draw_y60", expQ[12], 9'h09C);
        checkOutput("model_draw_x7_low", expQ[13], 9'h08B);
        checkOutput("model_draw_pay1", expQ[15], 9'h1FF);
        driveMove(4'b1000, 8, ev);
        checkOutput("y_wrap_60", posY, 60);

        repeat (7) applyStimulus(4'b0001, 10);
        checkOutput("x_at_14", posX, 14);
        planMove(4'b0001, 10, ev);
        checkOutput("model_len_even", expQ.size(), 16);
        checkOutput("model_draw_x0_low", expQ[9], 9'h088);
        driveMove(4'b0001, 10, ev);
        checkOutput("x_wrap_0", posX, 0);
        applyStimulus(4'b0010, 10);
        checkOutput("x_wrap_14", posX, 14);

        resetMidDraw();

        applyStimulus(4'b1100, 10);
        checkOutput("updown_y24", posY, 24);
        applyStimulus(4'b1000, 7);
        checkOutput("glitch_y24", posY, 24);
`ifdef LCD_BLOCK_AUTOREPEAT_EN
        repeatHoldTest(600);
`else
        applyStimulus(4'b0001, 200);
        checkOutput("hold_x8", posX, 8);
`endif

        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), $urandom_range(4, 20));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
